// File: rtl/nr2_core.sv
// Two-input NOR truth table with UDP semantics: any 1 forces 0, both 0 gives 1,
// otherwise X. Four-state NOR already resolves Z inputs to X, so Y is never Z.
module nr2_core (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a | b);

endmodule

// File: rtl/nr2.sv
// NOR leaf cell plus an optional clocked observation path: registered copy of Y,
// an X-seen flag and a modulo-2^CNT_W count of registered 0<->1 transitions.
module nr2 #(
  parameter int unsigned CNT_W = 8,
  parameter int          TPD   = 0
) (
  input  logic             A,
  input  logic             B,
  output logic             Y,
  input  logic             clk,
  input  logic             rst_,
  output logic             Y_r,
  output logic             x_flag,
  output logic [CNT_W-1:0] tgl_cnt
);

  // Propagation delay is back-annotated in gate-level timing flows; the RTL
  // model is zero-delay and only carries the parameter through.
  logic [31:0] unused_tpd;
  assign unused_tpd = TPD;

  logic y_core;
  logic y_known;

  nr2_core u_core (
    .a (A),
    .b (B),
    .y (y_core)
  );

  // Y depends only on A/B, so it stays valid with clk/rst_ left floating.
  assign Y       = y_core;
  assign y_known = !$isunknown(y_core);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      Y_r     <= 1'b0;
      x_flag  <= 1'b0;
      tgl_cnt <= '0;
    end else begin
      x_flag <= !y_known;
      // An unknown Y leaves the last known sample (and the count) untouched.
      if (y_known) begin
        Y_r <= y_core;
        if (y_core != Y_r) begin
          tgl_cnt <= tgl_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nr2.sv
// Self-checking bench for nr2: directed truth-table, reset, X and wrap steps,
// then random A/B sequences checked against a behavioural model of the cell.
module tb_nr2;

  logic       clk;
  logic       rst_;
  logic       a;
  logic       b;
  logic       y;
  logic       y_r;
  logic       x_flag;
  logic [7:0] tgl_cnt;

  logic       y2;
  logic       y_r2;
  logic       x_flag2;
  logic [1:0] tgl_cnt2;

  logic       pa;
  logic       pb;
  logic       py;
  logic       py_r;
  logic       px_flag;
  logic [7:0] ptgl_cnt;

  int checks;
  int errors;

  // reference model state
  logic m_yr;
  logic m_xf;
  int   m_cnt;

  nr2 #(.CNT_W(8)) dut (
    .A       (a),
    .B       (b),
    .Y       (y),
    .clk     (clk),
    .rst_    (rst_),
    .Y_r     (y_r),
    .x_flag  (x_flag),
    .tgl_cnt (tgl_cnt)
  );

  nr2 #(.CNT_W(2)) dut2 (
    .A       (a),
    .B       (b),
    .Y       (y2),
    .clk     (clk),
    .rst_    (rst_),
    .Y_r     (y_r2),
    .x_flag  (x_flag2),
    .tgl_cnt (tgl_cnt2)
  );

  // Positional hookup exercises the fixed port order; the observation pins idle.
  nr2 u_pos (pa, pb, py, 1'b0, 1'b0, py_r, px_flag, ptgl_cnt);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_nor(input logic ia, input logic ib);
    if (ia === 1'b1 || ib === 1'b1) return 1'b0;
    if (ia === 1'b0 && ib === 1'b0) return 1'b1;
    return 1'bx;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_yr  = 1'b0;
    m_xf  = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_edge();
    logic ey;
    ey = ref_nor(a, b);
    if (ey === 1'b0 || ey === 1'b1) begin
      if (ey !== m_yr) m_cnt++;
      m_yr = ey;
      m_xf = 1'b0;
    end else begin
      m_xf = 1'b1;
    end
  endtask

  task automatic check_obs(input string tag);
    check({tag, ".y_r"},     {31'd0, y_r},     {31'd0, m_yr});
    check({tag, ".x_flag"},  {31'd0, x_flag},  {31'd0, m_xf});
    check({tag, ".cnt"},     {24'd0, tgl_cnt}, 32'(m_cnt % 256));
    check({tag, ".cnt2"},    {30'd0, tgl_cnt2}, 32'(m_cnt % 4));
  endtask

  // Called at a negedge: drive inputs, check Y, clock once, check registers.
  task automatic step(input string tag, input logic na, input logic nb);
    a = na;
    b = nb;
    #1;
    check({tag, ".y"}, {31'd0, y}, {31'd0, ref_nor(na, nb)});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_obs(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_   = 1'b0;
    a      = 1'b0;
    b      = 1'b0;
    pa     = 1'b0;
    pb     = 1'b0;
    model_reset();

    // combinational table with the observation path held in reset
    #10 check("tt00", {31'd0, y}, {31'd0, ref_nor(a, b)});
    check("tt00_lit", {31'd0, y}, 32'd1);
    a = 1'b1; b = 1'b0; #10 check("tt10", {31'd0, y}, 32'd0);
    a = 1'b0; b = 1'b1; #10 check("tt01", {31'd0, y}, 32'd0);
    a = 1'b1; b = 1'b1; #10 check("tt11", {31'd0, y}, 32'd0);
    a = 1'b0; b = 1'bx; #10 check("tt0x", {31'd0, y}, {31'd0, ref_nor(a, b)});
    a = 1'b1; b = 1'bx; #10 check("tt1x", {31'd0, y}, 32'd0);
    check("rst.y_r", {31'd0, y_r}, 32'd0);
    check("rst.x_flag", {31'd0, x_flag}, 32'd0);
    check("rst.cnt", {24'd0, tgl_cnt}, 32'd0);

    // release reset away from an edge, then toggle Y 0 -> 1 -> 0
    a = 1'b1; b = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    step("tg0", 1'b1, 1'b0);
    step("tg1", 1'b0, 1'b0);
    step("tg2", 1'b1, 1'b0);
    check("tg.cnt_lit", {24'd0, tgl_cnt}, 32'd2);

    // reset in mid-cycle clears everything without a clock edge
    step("pre_rst", 1'b0, 1'b0);
    #2 rst_ = 1'b0;
    model_reset();
    #1 check_obs("mid_rst");
    check("mid_rst.y", {31'd0, y}, 32'd1);
    @(negedge clk);
    rst_ = 1'b1;

    // unknown B with A=0: flag raised and Y_r held, then recovers
    step("x0", 1'b1, 1'b0);
    step("x1", 1'b0, 1'bx);
    step("x2", 1'b0, 1'b0);
    check("x2.y_r_lit", {31'd0, y_r}, 32'd1);

    // four registered toggles wrap the 2-bit counter
    model_reset();
    rst_ = 1'b0;
    #1 rst_ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("wrap", (i % 2 == 0) ? 1'b0 : 1'b1, 1'b0);
    end
    check("wrap.cnt2_lit", {30'd0, tgl_cnt2}, 32'd0);

    // random stimulus, occasionally injecting unknowns
    for (int i = 0; i < 60; i++) begin
      logic ra;
      logic rb;
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) rb = 1'bx;
      step("rnd", ra, rb);
    end

    // positional instance across all known input combinations
    for (int i = 0; i < 4; i++) begin
      pa = i[1];
      pb = i[0];
      #10 check("pos.y", {31'd0, py}, {31'd0, ref_nor(pa, pb)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
